// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader and the CPU fetch stage.
// Holds the loader state encoding, frame field widths and the reset vector.
package loader_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LEN_W  = 16;

  localparam logic [ADDR_W-1:0] DEFAULT_BASE_ADDR = 16'h0100;
  localparam int unsigned       DEFAULT_MAX_WORDS = 128;

  typedef enum logic [2:0] {
    S_LEN_HI  = 3'd0,
    S_LEN_LO  = 3'd1,
    S_DATA_HI = 3'd2,
    S_DATA_LO = 3'd3,
    S_WRITE   = 3'd4,
    S_CSUM    = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } loader_state_t;

  // States that consume a byte from the upstream stream.
  function automatic logic state_ready(input loader_state_t s);
    return (s inside {S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CSUM});
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, instruction-memory write port and status lines of the loader.
interface prog_loader_if;
  import loader_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_byte;
  logic              in_ready;
  logic              restart;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              cpu_run;
  logic              load_err;

  modport master (
    output in_valid, in_byte, restart,
    input  in_ready, mem_we, mem_addr, mem_wdata, cpu_run, load_err
  );

  modport slave (
    input  in_valid, in_byte, restart,
    output in_ready, mem_we, mem_addr, mem_wdata, cpu_run, load_err
  );

endinterface

// File: rtl/prog_loader.sv
// Assembles a length-prefixed, XOR-checksummed byte stream into 16-bit words,
// writes them to instruction memory from BASE_ADDR and releases the CPU on success.
module prog_loader
  import loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int unsigned       MAX_WORDS = DEFAULT_MAX_WORDS
) (
  input  logic         clk,
  input  logic         rst_n,
  prog_loader_if.slave ldr
);

  loader_state_t     state_q;
  logic [BYTE_W-1:0] hi_q;
  logic [BYTE_W-1:0] xor_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [WORD_W-1:0] mem_wdata_q;
  logic              cpu_run_q;
  logic              load_err_q;

  logic              xfer_c;
  logic [LEN_W-1:0]  len_c;

  assign xfer_c = ldr.in_valid && state_ready(state_q);
  assign len_c  = {hi_q, ldr.in_byte};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LEN_HI;
      hi_q        <= '0;
      xor_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
      cpu_run_q   <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        S_LEN_HI: begin
          if (xfer_c) begin
            hi_q    <= ldr.in_byte;
            state_q <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer_c) begin
            len_q <= len_c;
            if (len_c > LEN_W'(MAX_WORDS)) begin
              state_q    <= S_ERROR;
              load_err_q <= 1'b1;
            end else if (len_c == '0) begin
              state_q <= S_CSUM;
            end else begin
              state_q <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (xfer_c) begin
            hi_q    <= ldr.in_byte;
            xor_q   <= xor_q ^ ldr.in_byte;
            state_q <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (xfer_c) begin
            mem_wdata_q <= {hi_q, ldr.in_byte};
            mem_addr_q  <= BASE_ADDR + ADDR_W'({idx_q, 1'b0});
            mem_we_q    <= 1'b1;
            idx_q       <= idx_q + LEN_W'(1);
            xor_q       <= xor_q ^ ldr.in_byte;
            state_q     <= S_WRITE;
          end
        end
        S_WRITE: begin
          // idx_q already counts the word being written this cycle.
          state_q <= (idx_q == len_q) ? S_CSUM : S_DATA_HI;
        end
        S_CSUM: begin
          if (xfer_c) begin
            if (xor_q == ldr.in_byte) begin
              state_q   <= S_DONE;
              cpu_run_q <= 1'b1;
            end else begin
              state_q    <= S_ERROR;
              load_err_q <= 1'b1;
            end
          end
        end
        S_DONE, S_ERROR: begin
          if (ldr.restart) begin
            state_q    <= S_LEN_HI;
            cpu_run_q  <= 1'b0;
            load_err_q <= 1'b0;
            xor_q      <= '0;
            idx_q      <= '0;
          end
        end
        default: state_q <= S_LEN_HI;
      endcase
    end
  end

  assign ldr.in_ready  = state_ready(state_q);
  assign ldr.mem_we    = mem_we_q;
  assign ldr.mem_addr  = mem_addr_q;
  assign ldr.mem_wdata = mem_wdata_q;
  assign ldr.cpu_run   = cpu_run_q;
  assign ldr.load_err  = load_err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed and randomized frames for prog_loader, checked against a frame-level model.
module tb_prog_loader;

  typedef logic [7:0]  bq_t[$];
  typedef logic [15:0] hq_t[$];
  typedef logic [31:0] wq_t[$];

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  wq_t  got;

  prog_loader_if bus();

  prog_loader #(.BASE_ADDR(16'h0100), .MAX_WORDS(128)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ldr  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Capture every memory write; the loader must not accept bytes while writing.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.mem_we === 1'b1) begin
      got.push_back({bus.mem_addr, bus.mem_wdata});
      chk("ready_low_in_write", {31'd0, bus.in_ready}, 32'd0);
    end
  end

  // Frame-level reference: which words land where and how the load ends.
  task automatic model(input bq_t f, output wq_t writes, output bit run, output bit err);
    int unsigned n;
    logic [7:0]  x;
    writes = {};
    n = {f[0], f[1]};
    if (n > 128) begin
      run = 1'b0;
      err = 1'b1;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < int'(n); i++) begin
      writes.push_back({16'(32'h100 + 2 * i), f[2 + 2 * i], f[3 + 2 * i]});
      x = x ^ f[2 + 2 * i] ^ f[3 + 2 * i];
    end
    run = (f[2 + 2 * n] == x);
    err = !run;
  endtask

  function automatic bq_t frame_of(input hq_t w, input bit bad);
    bq_t        f;
    logic [7:0] x = 8'h00;
    logic [15:0] n = 16'(w.size());
    f.push_back(n[15:8]);
    f.push_back(n[7:0]);
    foreach (w[i]) begin
      f.push_back(w[i][15:8]);
      f.push_back(w[i][7:0]);
      x = x ^ w[i][15:8] ^ w[i][7:0];
    end
    f.push_back(bad ? (x ^ 8'h5A) : x);
    return f;
  endfunction

  function automatic hq_t rand_words(input int n);
    hq_t w;
    for (int i = 0; i < n; i++) w.push_back(16'($urandom));
    return w;
  endfunction

  // Drive one byte; returns after the edge on which it was accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit accepted = 1'b0;
    int guard = 0;
    while (!accepted && guard < 200) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        if (bus.in_ready === 1'b1) accepted = 1'b1;
        @(posedge clk);
      end
    end
    if (!accepted) chk("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input bq_t f, input bit gaps);
    foreach (f[i]) send_byte(f[i], gaps);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bq_t f, input bit gaps);
    wq_t exp;
    bit  run, err;
    int  m;
    got.delete();
    model(f, exp, run, err);
    send_frame(f, gaps);
    chk({tag, "_cpu_run"}, {31'd0, bus.cpu_run}, {31'd0, run});
    chk({tag, "_load_err"}, {31'd0, bus.load_err}, {31'd0, err});
    chk({tag, "_ready_idle"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_write_count"}, got.size(), exp.size());
    m = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < m; i++) chk($sformatf("%s_write%0d", tag, i), got[i], exp[i]);
  endtask

  task automatic do_restart();
    @(negedge clk);
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    chk("restart_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("restart_cpu_run", {31'd0, bus.cpu_run}, 32'd0);
    chk("restart_load_err", {31'd0, bus.load_err}, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
    chk({tag, "_cpu_run"}, {31'd0, bus.cpu_run}, 32'd0);
    chk({tag, "_load_err"}, {31'd0, bus.load_err}, 32'd0);
    chk({tag, "_mem_addr"}, {16'd0, bus.mem_addr}, 32'h100);
    chk({tag, "_mem_wdata"}, {16'd0, bus.mem_wdata}, 32'd0);
  endtask

  initial begin
    bq_t f2, fbad, f;
    hq_t w;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    bus.restart  = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    f2 = {8'h00, 8'h02, 8'h21, 8'h28, 8'h31, 8'h2A, 8'h12};
    run_frame("two_word", f2, 1'b0);
    do_restart();

    w = rand_words(21);
    w.push_front(16'h2128);
    w.push_back(16'hFFFF);
    run_frame("fib23", frame_of(w, 1'b0), 1'b0);
    do_restart();

    fbad = {8'h00, 8'h02, 8'h21, 8'h28, 8'h31, 8'h2A, 8'h13};
    run_frame("bad_csum", fbad, 1'b0);
    do_restart();
    run_frame("after_err", f2, 1'b0);
    do_restart();

    f = {8'h00, 8'h81};
    run_frame("too_long", f, 1'b0);
    do_restart();
    f = {8'h00, 8'h00, 8'h00};
    run_frame("zero_len", f, 1'b0);
    do_restart();
    run_frame("max_len", frame_of(rand_words(128), 1'b0), 1'b0);
    do_restart();

    run_frame("gaps_a", f2, 1'b1);
    do_restart();
    run_frame("gaps_b", fbad, 1'b1);
    do_restart();

    for (int k = 0; k < 8; k++) begin
      run_frame($sformatf("rand%0d", k),
                frame_of(rand_words($urandom_range(0, 12)), 1'($urandom_range(0, 1))),
                1'($urandom_range(0, 1)));
      do_restart();
    end
    f = {8'($urandom_range(1, 255)), 8'($urandom)};
    run_frame("rand_too_long", f, 1'b0);
    do_restart();

    // Reset while the first word is being written.
    for (int i = 0; i < 4; i++) send_byte(f2[i], 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk_reset_outputs("midframe_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_frame("post_reset", frame_of(rand_words(5), 1'b0), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader that sits directly upstream of the CPU's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit words, and writes them to consecutive even byte addresses from `BASE_ADDR` (0x100 by default, the CPU reset vector). After it verifies a trailing XOR checksum, it asserts `cpu_run` to release the CPU. It replaces direct bench pokes of instruction RAM with a real load path.

## Interface
- `BASE_ADDR`, 16'h0100: byte address of the first word written.
- `MAX_WORDS`, 128: largest accepted word count. Larger counts are an error.
- `clk`  in  1  single clock. All logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream byte valid.
- `in_byte`  in  8  upstream byte.
- `in_ready`  out  1  loader can accept a byte. A transfer occurs on an edge where `in_valid && in_ready`.
- `restart`  in  1  single-cycle pulse, honoured only in DONE or ERROR.
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `mem_addr`  out  16  byte address. Always even.
- `mem_wdata`  out  16  word to write.
- `cpu_run`  out  1  high while the loaded image is valid; holds the CPU out of reset.
- `load_err`  out  1  high while in ERROR.

## Operation
- Frame format: LEN_HI, LEN_LO (word count N, big-endian), then N × (DATA_HI, DATA_LO), then CSUM.
- CSUM is the XOR of all 2N data bytes. Length bytes are excluded.
- States: LEN_HI → LEN_LO → (DATA_HI → DATA_LO → WRITE)×N → CSUM → DONE | ERROR.
- In LEN_LO, on acceptance, the count is checked:
  - N > MAX_WORDS → ERROR.
  - N == 0 → CSUM.
  - Otherwise → DATA_HI.
- DATA_LO acceptance loads `mem_wdata = {hi, lo}` and `mem_addr = BASE_ADDR + 2*index`.
- WRITE lasts one cycle with `mem_we` = 1. It then goes to DATA_HI if words remain, else to CSUM.
- CSUM acceptance: a running XOR equal to the received byte → DONE; any mismatch → ERROR.
- DONE: `cpu_run` = 1 and stays high until `restart` or reset.
- ERROR: `load_err` = 1 and `cpu_run` = 0. Words already written stay in memory; there is no rollback.
- `restart` in DONE/ERROR:
  - goes to LEN_HI;
  - clears `cpu_run`, `load_err`, the running XOR and the word index.
- `restart` in any other state is ignored.
- Address arithmetic is 16-bit and wraps modulo 2^16. Callers keep `BASE_ADDR + 2*MAX_WORDS` ≤ 0x10000.

## Timing
- Reset values:
  - state LEN_HI;
  - `in_ready` 1;
  - `mem_we`, `cpu_run` and `load_err` 0;
  - `mem_addr` = `BASE_ADDR`;
  - `mem_wdata` 0;
  - internal XOR, index and count 0.
- `in_ready` = 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CSUM. It is 0 in WRITE, DONE and ERROR. It is decoded from registered state only, never from `in_valid`.
- `mem_we` is high exactly one cycle, in the cycle after the DATA_LO transfer. `mem_addr`/`mem_wdata` are stable during that cycle and until the next DATA_LO transfer.
- Minimum throughput is 3 cycles per word. `in_valid` gaps stall the FSM without side effects.
- `cpu_run` rises in the cycle after the accepted, matching CSUM byte.
- `rst_n` asserted mid-frame: all outputs return to reset values immediately (async). Partial memory contents are left as written.

## Structure
- Shared package `loader_pkg`:
  - state enum `loader_state_t`;
  - frame-field constants;
  - default `BASE_ADDR` (reset vector 16'h0100), so the CPU fetch stage uses the same constant.
- Single module, no sub-module. The byte pairing, checksum and address counter are each a few registers.
- `prog_loader` instantiates beside the `Computer` instruction memory. Its write port muxes with nothing else during boot.

## Test plan
- Two-word frame 00 02 21 28 31 2A 12 → writes 0x2128@0x100, then 0x312A@0x102; `cpu_run` = 1; `load_err` = 0.
- Full 23-word Fibonacci image (0x2128 … 0xFFFF, correct CSUM) → 23 writes at 0x100..0x12C in order; `cpu_run` = 1.
- Same two-word frame with CSUM 0x13 → both writes occur, then `load_err` = 1, `cpu_run` = 0. `restart` then a correct frame → `cpu_run` = 1.
- Frame 00 81 → ERROR right after LEN_LO, no `mem_we`. Frame 00 00 00 → DONE with zero writes.
- Random `in_valid` gaps on the two-word frame → identical writes and CSUM result. `in_ready` is low during each WRITE cycle.
- `rst_n` low after the first DATA_LO transfer → outputs at reset values. A fresh full frame afterwards loads correctly from 0x100.
